// File: rtl/lcd_pkg.sv
// Shared constants, types and address mapping for the HD44780 bus receiver.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN   = 7'd16;
  localparam int unsigned NUM_CHARS = 32;

  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  localparam logic [1:0] ST_INIT8  = 2'd0;
  localparam logic [1:0] ST_NIB_HI = 2'd1;
  localparam logic [1:0] ST_NIB_LO = 2'd2;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [3:0] d;
  } lcd_xfer_t;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } ddram_slot_t;

  // Each visible line is a 16-entry window; the upper address bits select the line.
  function automatic ddram_slot_t ddram_slot(input logic [6:0] addr);
    ddram_slot_t s;
    s.hit = 1'b0;
    s.idx = '0;
    if (addr[6:4] == LINE1_BASE[6:4]) begin
      s.hit = 1'b1;
      s.idx = {1'b0, addr[3:0]};
    end else if (addr[6:4] == LINE2_BASE[6:4]) begin
      s.hit = 1'b1;
      s.idx = {1'b1, addr[3:0]};
    end
    return s;
  endfunction

endpackage

// File: rtl/lcd_e_sync.sv
// Input synchronizers, lcd_e fall detector and saturating e-high width counter.
module lcd_e_sync
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_E_HIGH  = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [3:0] d_i,
  output logic       fall_o,
  output lcd_xfer_t  xfer_o,
  output logic       pulse_ok_o
);

  localparam int unsigned CW = $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_E_HIGH);

  typedef struct packed {
    logic      e;
    lcd_xfer_t x;
  } bus_t;

  bus_t [SYNC_STAGES-1:0] sync_q;
  logic                   e_s;
  logic                   e_prev_q;
  logic                   fall;
  logic                   fall_q;
  logic                   ok_q;
  lcd_xfer_t              xfer_q;
  logic [CW-1:0]          cnt_q;

  assign e_s  = sync_q[SYNC_STAGES-1].e;
  assign fall = e_prev_q & ~e_s;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q   <= '0;
      e_prev_q <= 1'b0;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
      ok_q     <= 1'b0;
      xfer_q   <= '0;
    end else begin
      sync_q[0] <= {e_i, rs_i, rw_i, d_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev_q <= e_s;
      fall_q   <= fall;
      // Width counter restarts whenever e is low, so at the fall it holds this pulse's width.
      if (e_s) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
      if (fall) begin
        xfer_q <= sync_q[SYNC_STAGES-1].x;
        ok_q   <= (cnt_q == CNT_MAX);
      end
    end
  end

  assign fall_o     = fall_q;
  assign xfer_o     = xfer_q;
  assign pulse_ok_o = ok_q;

endmodule

// File: rtl/lcd_hd44780_receiver.sv
// Receive side of the HD44780 4-bit write bus: rebuilds bytes, executes the
// controller's command subset and keeps a 2x16 shadow of the display.
module lcd_hd44780_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_E_HIGH  = 8,
  parameter logic [7:0]  CLEAR_CHAR  = lcd_pkg::CLEAR_CHAR
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_e,
  input  logic [3:0]   lcd_d,
  output logic [255:0] oChars,
  output logic [6:0]   oAddr,
  output logic         oDisplayOn,
  output logic         oFourBitMode,
  output logic         oByteValid,
  output logic [7:0]   oByte,
  output logic         oByteIsData,
  output logic         oFrameDone,
  output logic         oError
);

  import lcd_pkg::*;

  logic        fall;
  lcd_xfer_t   xfer;
  logic        pulse_ok;

  logic [1:0]  state_q, state_d;
  logic [3:0]  hi_q, hi_d;
  logic        hi_rs_q, hi_rs_d;
  logic [7:0]  chars_q [NUM_CHARS];
  logic [7:0]  chars_d [NUM_CHARS];
  logic [6:0]  addr_q, addr_d;
  logic        disp_q, disp_d;
  logic        four_q, four_d;
  logic        inc_q, inc_d;
  logic        bvalid_q, bvalid_d;
  logic [7:0]  byte_q, byte_d;
  logic        bdata_q, bdata_d;
  logic        frame_q, frame_d;
  logic        err_q, err_d;

  logic [7:0]  cur;
  ddram_slot_t slot;

  lcd_e_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_E_HIGH  (MIN_E_HIGH)
  ) u_sync (
    .Clock      (Clock),
    .Reset      (Reset),
    .e_i        (lcd_e),
    .rs_i       (lcd_rs),
    .rw_i       (lcd_rw),
    .d_i        (lcd_d),
    .fall_o     (fall),
    .xfer_o     (xfer),
    .pulse_ok_o (pulse_ok)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    hi_rs_d  = hi_rs_q;
    chars_d  = chars_q;
    addr_d   = addr_q;
    disp_d   = disp_q;
    four_d   = four_q;
    inc_d    = inc_q;
    err_d    = err_q;
    bvalid_d = 1'b0;
    byte_d   = byte_q;
    bdata_d  = bdata_q;
    frame_d  = 1'b0;
    cur      = {hi_q, xfer.d};
    slot     = ddram_slot(addr_q);

    if (fall) begin
      if (!pulse_ok || xfer.rw) begin
        err_d = 1'b1;
      end else begin
        unique case (state_q)
          ST_INIT8: begin
            // 8-bit wake-up writes carry only D7..D4; only the 4-bit switch matters.
            if (!xfer.rs && xfer.d == INIT_NIB_4BIT) begin
              four_d  = 1'b1;
              state_d = ST_NIB_HI;
            end
          end
          ST_NIB_HI: begin
            hi_d    = xfer.d;
            hi_rs_d = xfer.rs;
            state_d = ST_NIB_LO;
          end
          ST_NIB_LO: begin
            state_d  = ST_NIB_HI;
            bvalid_d = 1'b1;
            byte_d   = cur;
            bdata_d  = xfer.rs;
            if (hi_rs_q != xfer.rs) err_d = 1'b1;
            if (xfer.rs) begin
              if (slot.hit) chars_d[slot.idx] = cur;
              frame_d = (addr_q == LINE2_BASE + LINE_LEN - 7'd1);
              addr_d  = inc_q ? addr_q + 7'd1 : addr_q - 7'd1;
            end else if (cur >= CMD_DDRAM) begin
              addr_d = cur[6:0];
            end else if (cur < CMD_SHIFT) begin
              // Shift, function set and CGRAM addressing leave the shadow untouched.
              if (cur >= CMD_DISPLAY) begin
                disp_d = cur[2];
              end else if (cur >= CMD_ENTRY) begin
                inc_d = cur[1];
              end else if (cur >= CMD_HOME) begin
                addr_d = '0;
              end else if (cur == CMD_CLEAR) begin
                for (int i = 0; i < NUM_CHARS; i++) chars_d[i] = CLEAR_CHAR;
                addr_d = '0;
                inc_d  = 1'b1;
              end
            end
          end
          default: state_d = ST_INIT8;
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_INIT8;
      hi_q     <= '0;
      hi_rs_q  <= 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) chars_q[i] <= CLEAR_CHAR;
      addr_q   <= '0;
      disp_q   <= 1'b0;
      four_q   <= 1'b0;
      inc_q    <= 1'b1;
      bvalid_q <= 1'b0;
      byte_q   <= '0;
      bdata_q  <= 1'b0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      hi_rs_q  <= hi_rs_d;
      chars_q  <= chars_d;
      addr_q   <= addr_d;
      disp_q   <= disp_d;
      four_q   <= four_d;
      inc_q    <= inc_d;
      bvalid_q <= bvalid_d;
      byte_q   <= byte_d;
      bdata_q  <= bdata_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_pack
    assign oChars[255-8*g -: 8] = chars_q[g];
  end

  assign oAddr        = addr_q;
  assign oDisplayOn   = disp_q;
  assign oFourBitMode = four_q;
  assign oByteValid   = bvalid_q;
  assign oByte        = byte_q;
  assign oByteIsData  = bdata_q;
  assign oFrameDone   = frame_q;
  assign oError       = err_q;

endmodule

// File: tb/tb_lcd_hd44780_receiver.sv
// Scoreboard bench: stimulus pushes expected bytes and shadow snapshots; a monitor pops on each byte strobe.
module tb_lcd_hd44780_receiver;

  localparam int SYNC = 2;
  localparam int MINE = 8;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [3:0]   lcd_d = 4'h0;
  logic [255:0] oChars;
  logic [6:0]   oAddr;
  logic         oDisplayOn, oFourBitMode, oByteValid, oByteIsData, oFrameDone, oError;
  logic [7:0]   oByte;

  lcd_hd44780_receiver #(.SYNC_STAGES(SYNC), .MIN_E_HIGH(MINE), .CLEAR_CHAR(8'h20)) dut (
    .Clock(Clock), .Reset(Reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d),
    .oChars(oChars), .oAddr(oAddr), .oDisplayOn(oDisplayOn), .oFourBitMode(oFourBitMode),
    .oByteValid(oByteValid), .oByte(oByte), .oByteIsData(oByteIsData), .oFrameDone(oFrameDone),
    .oError(oError)
  );

  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]   b;
    logic         rs;
    logic [255:0] chars;
    logic [6:0]   addr;
    logic         disp;
    logic         frame;
    logic         err;
    int unsigned  at;
  } exp_t;

  exp_t q[$];
  exp_t me, none;
  int   checks = 0, errors = 0, frames_seen = 0, m_frames = 0;

  // Reference model of the display as the controller sees it.
  logic [7:0] m_chars [32];
  logic [6:0] m_addr;
  bit         m_inc, m_disp, m_four, m_err;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [255:0] m_pack();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = m_chars[i];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
    m_addr = 7'h00; m_inc = 1'b1; m_disp = 1'b0; m_four = 1'b0; m_err = 1'b0;
  endtask

  task automatic apply(input bit rs, input logic [7:0] b, output bit fr);
    fr = 1'b0;
    if (rs) begin
      fr = (m_addr == 7'h4F);
      if (m_addr <= 7'h0F) m_chars[m_addr[4:0]] = b;
      else if (m_addr >= 7'h40 && m_addr <= 7'h4F) m_chars[5'(m_addr - 7'h30)] = b;
      m_addr = m_inc ? m_addr + 7'd1 : m_addr - 7'd1;
    end else if (b[7]) m_addr = b[6:0];
    else if (b >= 8'h10) m_addr = m_addr;
    else if (b >= 8'h08) m_disp = b[2];
    else if (b >= 8'h04) m_inc = b[1];
    else if (b >= 8'h02) m_addr = 7'h00;
    else if (b == 8'h01) begin
      for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
      m_addr = 7'h00; m_inc = 1'b1;
    end
    if (fr) m_frames++;
  endtask

  function automatic int wid();
    return MINE + int'($urandom_range(0, 6));
  endfunction

  // One e strobe of w cycles; a pushed expectation is stamped with its strobe cycle.
  task automatic pulse(input bit rs, input bit rw, input logic [3:0] d, input int w,
                       input bit push, input exp_t ex);
    exp_t t;
    @(negedge Clock); lcd_rs = rs; lcd_rw = rw; lcd_d = d;
    @(negedge Clock); lcd_e = 1'b1;
    repeat (w) @(negedge Clock);
    lcd_e = 1'b0;
    t = ex;
    t.at = cyc + 1 + SYNC + 1;
    if (push) q.push_back(t);
    repeat (2) @(negedge Clock);
  endtask

  task automatic bad_pulse(input bit use_rw);
    if (use_rw) pulse(1'($urandom), 1'b1, 4'($urandom), wid(), 1'b0, none);
    else pulse(1'($urandom), 1'b0, 4'($urandom), int'($urandom_range(1, MINE - 1)), 1'b0, none);
    m_err = 1'b1;
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b, input bit flip_hi, input bit bad_mid);
    exp_t e;
    bit   fr;
    pulse(rs ^ flip_hi, 1'b0, b[7:4], wid(), 1'b0, none);
    if (bad_mid) bad_pulse(1'($urandom));
    if (flip_hi) m_err = 1'b1;
    apply(rs, b, fr);
    e.b = b; e.rs = rs; e.chars = m_pack(); e.addr = m_addr; e.disp = m_disp;
    e.frame = fr; e.err = m_err; e.at = 0;
    pulse(rs, 1'b0, b[3:0], wid(), 1'b1, e);
  endtask

  task automatic init_seq(input int w);
    pulse(1'b0, 1'b0, 4'h3, w, 1'b0, none);
    pulse(1'b0, 1'b0, 4'h3, w, 1'b0, none);
    pulse(1'b0, 1'b0, 4'h3, w, 1'b0, none);
    pulse(1'b0, 1'b0, 4'h2, w, 1'b0, none);
    m_four = 1'b1;
    repeat (6) @(negedge Clock);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    repeat (4) @(negedge Clock);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_d = 4'h0;
    repeat (3) @(negedge Clock);
    m_reset();
    Reset = 1'b0;
  endtask

  always @(negedge Clock) begin
    if (!Reset && oFrameDone) frames_seen++;
    if (!Reset && oByteValid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe got oByte=%h want no strobe", oByte);
      end else begin
        me = q.pop_front();
        chk("byte", oByte, me.b);
        chk("is_data", oByteIsData, me.rs);
        chk("latency_cycle", cyc, me.at);
        chk("chars", oChars, me.chars);
        chk("addr", oAddr, me.addr);
        chk("display_on", oDisplayOn, me.disp);
        chk("frame_done", oFrameDone, me.frame);
        chk("error", oError, me.err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] lst [5];
  logic [7:0] hola [4];
  int         k;
  logic [7:0] rb;
  logic [6:0] ra;
  bit         rrs;

  initial begin
    m_reset();
    repeat (3) @(negedge Clock);
    chk("rst_chars", oChars, {32{8'h20}});
    chk("rst_addr", oAddr, 7'h00);
    chk("rst_display", oDisplayOn, 1'b0);
    chk("rst_four", oFourBitMode, 1'b0);
    chk("rst_valid", oByteValid, 1'b0);
    chk("rst_byte", oByte, 8'h00);
    chk("rst_is_data", oByteIsData, 1'b0);
    chk("rst_frame", oFrameDone, 1'b0);
    chk("rst_error", oError, 1'b0);
    Reset = 1'b0;

    init_seq(13);
    chk("init_four", oFourBitMode, m_four);
    chk("init_error", oError, 1'b0);

    lst[0] = 8'h28; lst[1] = 8'h08; lst[2] = 8'h06; lst[3] = 8'h0C; lst[4] = 8'h01;
    for (int i = 0; i < 5; i++) send_byte(1'b0, lst[i], 1'b0, 1'b0);
    drain();
    chk("setup_display_on", oDisplayOn, 1'b1);
    chk("setup_chars", oChars, {32{8'h20}});
    chk("setup_addr", oAddr, 7'h00);

    hola[0] = 8'h48; hola[1] = 8'h4F; hola[2] = 8'h4C; hola[3] = 8'h41;
    for (int i = 0; i < 4; i++) send_byte(1'b1, hola[i], 1'b0, 1'b0);
    drain();
    chk("hola_chars", oChars[255:224], 32'h484F4C41);
    chk("hola_addr", oAddr, 7'h04);

    send_byte(1'b0, 8'hC0, 1'b0, 1'b0);
    send_byte(1'b1, 8'h5A, 1'b0, 1'b0);
    drain();
    chk("line2_idx16", oChars[127:120], 8'h5A);
    chk("line2_addr", oAddr, 7'h41);

    send_byte(1'b0, 8'hC0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    drain();
    chk("frame_count_line2", frames_seen, 1);

    pulse(1'b1, 1'b0, 4'h4, 3, 1'b0, none);
    m_err = 1'b1;
    repeat (6) @(negedge Clock);
    chk("short_pulse_error", oError, 1'b1);
    pulse(1'b0, 1'b1, 4'h8, 13, 1'b0, none);
    repeat (6) @(negedge Clock);
    chk("rw_error_sticky", oError, 1'b1);
    send_byte(1'b1, 8'h21, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 4'h4, MINE - 1, 1'b0, none);
    send_byte(1'b1, 8'h22, 1'b0, 1'b0);
    drain();

    // Reset with half a byte received.
    pulse(1'b1, 1'b0, 4'h4, 13, 1'b0, none);
    do_reset();
    repeat (2) @(negedge Clock);
    chk("midbyte_chars", oChars, {32{8'h20}});
    chk("midbyte_four", oFourBitMode, 1'b0);
    chk("midbyte_error", oError, 1'b0);
    init_seq(wid());
    send_byte(1'b1, 8'h41, 1'b0, 1'b0);
    drain();
    chk("midbyte_a", oChars[255:248], 8'h41);

    for (int n = 0; n < 100; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 5) begin
        rrs = 1'b1; rb = 8'($urandom_range(32, 126));
      end else if (k < 7) begin
        case ($urandom_range(0, 3))
          0: ra = 7'($urandom_range(0, 15));
          1: ra = 7'(7'h40 + $urandom_range(0, 15));
          2: ra = ($urandom_range(0, 1) != 0) ? 7'h4F : 7'h00;
          default: ra = 7'($urandom);
        endcase
        rrs = 1'b0; rb = {1'b1, ra};
      end else if (k == 7) begin
        rrs = 1'b0; rb = 8'($urandom_range(2, 127));
      end else if (k == 8) begin
        rrs = 1'b0; rb = {5'b00001, 3'($urandom)};
      end else begin
        rrs = 1'b0;
        rb = ($urandom_range(0, 4) == 0) ? 8'h01 : {6'b000001, 2'($urandom)};
      end
      send_byte(rrs, rb, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) bad_pulse(1'($urandom));
    end
    drain();
    chk("final_chars", oChars, m_pack());
    chk("final_addr", oAddr, m_addr);
    chk("final_error", oError, m_err);
    chk("final_frames", frames_seen, m_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_receiver.md
Name: lcd_hd44780_receiver

Overview:
- Receive-side model of the HD44780 4-bit write bus driven by the LCD controller.
- Samples lcd_rs, lcd_rw, lcd_e and lcd_d on the falling edge of lcd_e, reassembles nibbles into bytes, and executes the command subset the controller uses.
- Maintains a 2x16 character shadow buffer. Used on-chip for loopback self-check (oChars compared with the chars input of the controller) and in simulation as the bus responder.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on all LCD inputs; must be >= 2.
- MIN_E_HIGH, 8: minimum lcd_e high width, counted in synchronized Clock cycles; a shorter pulse is a protocol error.
- CLEAR_CHAR, 8'h20: fill value on reset and on Clear Display.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- lcd_rs  in  1  register select (0 = command, 1 = data)
- lcd_rw  in  1  read/write (only 0 is legal)
- lcd_e  in  1  enable strobe
- lcd_d  in  4  data nibble {D7,D6,D5,D4}
- oChars  out  256  buffer; char 0 (addr 0x00) at [255:248], char 31 (addr 0x4F) at [7:0]
- oAddr  out  7  DDRAM address counter
- oDisplayOn  out  1  D bit of last Display Control command
- oFourBitMode  out  1  4-bit mode has been entered
- oByteValid  out  1  one-cycle strobe: a byte was completed
- oByte  out  8  completed byte; held until the next strobe
- oByteIsData  out  1  rs of the completed byte
- oFrameDone  out  1  one-cycle strobe: data was written to addr 0x4F
- oError  out  1  sticky protocol error

Behaviour:
- Reset: Clock, synchronous, active-high. Reset wins over every other event.
- Reset values: oChars all CLEAR_CHAR; oAddr 0; oDisplayOn 0; oFourBitMode 0; oByte 0; oByteIsData 0; all strobes 0; oError 0; FSM in INIT8; pulse counter 0.
- Input capture:
  - All four inputs pass through SYNC_STAGES flops.
  - The fall of synchronized e latches synchronized rs/rw/d.
  - The pulse counter counts synchronized e high cycles and saturates at MIN_E_HIGH.
- Transfer validity: a transfer is valid only if the counter reached MIN_E_HIGH and rw = 0.
- Invalid transfer: discarded, FSM phase unchanged, oError <= 1. oError stays set until Reset.
- FSM states:
  - INIT8: each valid transfer is a complete byte {d,4'b0}.
    - rs=0 and d=4'h2: set oFourBitMode, go to NIB_HI.
    - d=4'h3: stay in INIT8.
  - NIB_HI: store the nibble as the high half, go to NIB_LO.
  - NIB_LO: form the byte {hi,d}, execute it, go to NIB_HI.
- rs mismatch between the two halves of a byte: the low-half rs is used, and oError <= 1.
- Latency: oByteValid pulses SYNC_STAGES+1 cycles after the first Clock edge that samples lcd_e = 0. Buffer and register updates take effect on the same edge as the strobe.
- Command decode (rs=0), highest set bit wins:
  - 0x80|a: oAddr <= a[6:0].
  - 0x20–0x3F: function set; no state change.
  - 0x08–0x0F: oDisplayOn <= byte[2].
  - 0x04–0x07: increment flag <= byte[1]; reset value of the flag is 1.
  - 0x02–0x03: oAddr <= 0.
  - 0x01: all 32 entries <= CLEAR_CHAR in one cycle; oAddr <= 0; increment flag <= 1.
  - 0x00: no-op.
- Data (rs=1):
  - Address-to-index mapping: addr 0x00–0x0F maps to index addr; addr 0x40–0x4F maps to index 16+(addr-0x40). Any other address writes nothing.
  - After a data write, oAddr increments or decrements per the flag, modulo 128.
  - Writing addr 0x4F also pulses oFrameDone.
- Reset mid-byte: a half-received byte is lost, and the FSM restarts in INIT8.

Decomposition:
- Package lcd_pkg holds:
  - command opcode constants CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPLAY, CMD_FUNC, CMD_DDRAM;
  - LINE1_BASE = 7'h00 and LINE2_BASE = 7'h40;
  - the FSM state encoding and CLEAR_CHAR.
- Sub-module lcd_e_sync: per-bit synchronizers, e fall detector, saturating pulse-width counter.
  - Outputs: one-cycle fall strobe, latched rs/rw/d, pulse_ok.

Test Plan:
- Reset, then init nibbles 3,3,3,2 (rs=0, e high 13 cycles) -> oFourBitMode=1 after the 4th; no oByteValid for 3/3/3; oError=0.
- After init, send bytes 0x28, 0x08, 0x06, 0x0C, 0x01 -> five oByteValid strobes with those oByte values; oDisplayOn=1; oChars all 0x20; oAddr=0.
- Data 'H','O','L','A' -> oChars[255:224]=0x484F4C41; oAddr=4.
- Command 0xC0, then data 'Z' -> index 16 = 0x5A; oAddr=0x41.
- Write 16 chars to line 2 -> oFrameDone pulses once, on the 0x4F write.
- e pulse 3 cycles wide -> transfer ignored, oError=1; then rw=1 transfer -> ignored, oError stays 1.
- Reset after the high nibble of 0x48 -> state back to INIT8, oChars all 0x20; re-init, then 'A' -> index 0 = 0x41.
